// File: rtl/guess_entry_ctrl_pkg.sv
// Shared constants and types for the 1A2B guess-row entry controller.
package guess_entry_ctrl_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int DIGIT_W   = 4;
  localparam int IDX_W     = 2;

  // Code a slot holds when no digit has been written; the tile renders it blank.
  localparam logic [DIGIT_W-1:0] EMPTY_CODE = 4'hF;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT  = 4'd9;

  typedef enum logic {
    EDIT = 1'b0,
    SEND = 1'b1
  } state_e;

  // Slot i sits on bits [4i+3:4i] when flattened onto the digits bus.
  typedef logic [NUM_SLOTS-1:0][DIGIT_W-1:0] slots_t;

  function automatic logic [NUM_SLOTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_SLOTS'(1) << idx;
  endfunction

endpackage

// File: rtl/guess_entry_ctrl_click_edge_detect.sv
// Registered rising-edge detector for the four tile onclick levels, with a
// lowest-index-wins priority encoder so simultaneous clicks pick one tile.
module click_edge_detect
  import guess_entry_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] onclick,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  logic [NUM_SLOTS-1:0] prev_q;
  logic [NUM_SLOTS-1:0] prev_d;
  logic [NUM_SLOTS-1:0] rise;

  // Previous level is simply the current level one cycle later.
  always_comb prev_d = onclick;

  // Remember last cycle's onclick levels so a held button yields one edge.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  // Rising edges, then a descending scan so the lowest set index is last written.
  // NOTE: idx gets a default before the loop so no latch is inferred.
  always_comb begin
    rise = onclick & ~prev_q;
    hit  = |rise;
    idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (rise[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Entry controller for one guess row: slot selection by tile click, digit
// writes from the recogniser with duplicate rejection, border blink on the
// active tile, and a valid/ready handoff of a complete guess.
module guess_entry_ctrl
  import guess_entry_ctrl_pkg::*;
#(
  parameter int BLINK_CYCLES = 25_000_000
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SLOTS-1:0]           onclick,
  input  logic                           recog_valid,
  input  logic [DIGIT_W-1:0]             recog_digit,
  input  logic                           submit,
  input  logic                           clear,
  input  logic                           guess_ready,
  output logic [NUM_SLOTS*DIGIT_W-1:0]   digits,
  output logic [NUM_SLOTS-1:0]           active,
  output logic [NUM_SLOTS-1:0]           border_disable,
  output logic                           guess_valid,
  output logic [NUM_SLOTS*DIGIT_W-1:0]   guess,
  output logic                           err_dup,
  output logic                           err_incomplete
);

  localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  state_e             state_q, state_d;
  slots_t             slots_q, slots_d;
  logic [IDX_W-1:0]   act_idx_q, act_idx_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               err_dup_q, err_dup_d;
  logic               err_inc_q, err_inc_d;

  logic               click_hit;
  logic [IDX_W-1:0]   click_idx;
  logic               all_filled;
  logic               is_dup;
  logic               digit_ok;

  click_edge_detect u_click (
    .clk     (clk),
    .rst     (rst),
    .onclick (onclick),
    .hit     (click_hit),
    .idx     (click_idx)
  );

  // Row completeness and duplicate check against every slot except the active one.
  always_comb begin
    all_filled = 1'b1;
    is_dup     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots_q[i] == EMPTY_CODE) all_filled = 1'b0;
      if ((IDX_W'(i) != act_idx_q) && (slots_q[i] == recog_digit)) is_dup = 1'b1;
    end
    digit_ok = recog_valid && (recog_digit <= MAX_DIGIT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EDIT;
    else     state_q <= state_d;
  end

  // FSM next state: clear suppresses submit; a transfer returns to editing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EDIT: if (submit && !clear && all_filled) state_d = SEND;
      SEND: if (guess_ready)                    state_d = EDIT;
      default:                                  state_d = EDIT;
    endcase
  end

  // FSM outputs: offer the guess in SEND, blink only the active border in EDIT.
  always_comb begin
    guess_valid    = (state_q == SEND);
    border_disable = {NUM_SLOTS{phase_q && (state_q == EDIT)}} & active;
  end

  // Slot, selection, error and blink next-state logic.
  always_comb begin
    slots_d   = slots_q;
    act_idx_d = act_idx_q;
    err_dup_d = 1'b0;
    err_inc_d = 1'b0;

    if (state_q == EDIT) begin
      if (clear) begin
        slots_d   = {NUM_SLOTS{EMPTY_CODE}};
        act_idx_d = '0;
      end else begin
        if (digit_ok) begin
          if (is_dup) begin
            err_dup_d = 1'b1;
          end else begin
            slots_d[act_idx_q] = recog_digit;
            if (act_idx_q != IDX_W'(NUM_SLOTS - 1)) act_idx_d = act_idx_q + IDX_W'(1);
          end
        end
        // A click overrides any auto-advance from a same-cycle write.
        if (click_hit) act_idx_d = click_idx;
        if (submit && !all_filled) err_inc_d = 1'b1;
      end
    end else if (guess_ready) begin
      slots_d   = {NUM_SLOTS{EMPTY_CODE}};
      act_idx_d = '0;
    end

    // A new selection restarts the blink so its border shows at once.
    if (act_idx_d != act_idx_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
      phase_d     = phase_q;
    end
  end

  // Datapath registers; the slot array is only four nibbles so it is reset too.
  // NOTE: slots are reset explicitly because the empty code is visible state, not don't-care storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= {NUM_SLOTS{EMPTY_CODE}};
      act_idx_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      err_dup_q   <= 1'b0;
      err_inc_q   <= 1'b0;
    end else begin
      slots_q     <= slots_d;
      act_idx_q   <= act_idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      err_dup_q   <= err_dup_d;
      err_inc_q   <= err_inc_d;
    end
  end

  assign digits         = slots_q;
  assign guess          = slots_q;
  assign active         = idx_to_onehot(act_idx_q);
  assign err_dup        = err_dup_q;
  assign err_incomplete = err_inc_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl: expectations are queued as stimulus is
// applied and drained against the DUT outputs on the falling clock edge.
module tb_guess_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  onclick;
  logic        recog_valid;
  logic [3:0]  recog_digit;
  logic        submit;
  logic        clear;
  logic        guess_ready;
  logic [15:0] digits;
  logic [3:0]  active;
  logic [3:0]  border_disable;
  logic        guess_valid;
  logic [15:0] guess;
  logic        err_dup;
  logic        err_incomplete;

  int passed = 0;
  int total  = 0;

  typedef enum int {S_DIGITS, S_ACTIVE, S_BORDER, S_GVALID, S_GUESS, S_EDUP, S_EINC} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  guess_entry_ctrl #(.BLINK_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .onclick        (onclick),
    .recog_valid    (recog_valid),
    .recog_digit    (recog_digit),
    .submit         (submit),
    .clear          (clear),
    .guess_ready    (guess_ready),
    .digits         (digits),
    .active         (active),
    .border_disable (border_disable),
    .guess_valid    (guess_valid),
    .guess          (guess),
    .err_dup        (err_dup),
    .err_incomplete (err_incomplete)
  );

  function automatic logic [15:0] observe(input sel_e s);
    case (s)
      S_DIGITS: return digits;
      S_ACTIVE: return {12'h0, active};
      S_BORDER: return {12'h0, border_disable};
      S_GVALID: return {15'h0, guess_valid};
      S_GUESS:  return guess;
      S_EDUP:   return {15'h0, err_dup};
      S_EINC:   return {15'h0, err_incomplete};
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare it with the current outputs.
  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic recog(input logic [3:0] d);
    recog_valid = 1'b1;
    recog_digit = d;
    step();
    recog_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic pulse_submit();
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_val({tag, "_digits"}, S_DIGITS, 16'hFFFF);
    expect_val({tag, "_active"}, S_ACTIVE, 16'h0001);
    expect_val({tag, "_border"}, S_BORDER, 16'h0000);
    expect_val({tag, "_gvalid"}, S_GVALID, 16'h0000);
    expect_val({tag, "_edup"},   S_EDUP,   16'h0000);
    expect_val({tag, "_einc"},   S_EINC,   16'h0000);
  endtask

  initial begin
    rst = 1'b1; onclick = '0; recog_valid = 1'b0; recog_digit = '0;
    submit = 1'b0; clear = 1'b0; guess_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    expect_reset_state("reset");
    check();

    // Fill the row in order; active advances and parks on slot 3.
    recog(4'd1); recog(4'd2); recog(4'd3); recog(4'd4);
    expect_val("fill_digits", S_DIGITS, 16'h4321);
    expect_val("fill_active", S_ACTIVE, 16'h0008);
    expect_val("fill_edup",   S_EDUP,   16'h0000);
    check();

    // Out-of-range digit ignored silently; rewriting own value is legal.
    recog(4'hA);
    expect_val("bad_digit_digits", S_DIGITS, 16'h4321);
    expect_val("bad_digit_edup",   S_EDUP,   16'h0000);
    check();
    recog(4'd4);
    expect_val("self_rewrite_digits", S_DIGITS, 16'h4321);
    expect_val("self_rewrite_edup",   S_EDUP,   16'h0000);
    check();

    // Duplicate rejection.
    pulse_clear();
    expect_val("clear_digits", S_DIGITS, 16'hFFFF);
    expect_val("clear_active", S_ACTIVE, 16'h0001);
    check();
    recog(4'd5); recog(4'd6); recog(4'd7);
    recog(4'd6);
    expect_val("dup_digits", S_DIGITS, 16'hF765);
    expect_val("dup_edup",   S_EDUP,   16'h0001);
    expect_val("dup_active", S_ACTIVE, 16'h0008);
    check();
    step();
    expect_val("dup_edup_end", S_EDUP, 16'h0000);
    check();

    // Incomplete submit.
    pulse_submit();
    expect_val("inc_einc",   S_EINC,   16'h0001);
    expect_val("inc_gvalid", S_GVALID, 16'h0000);
    check();
    step();
    expect_val("inc_einc_end",   S_EINC,   16'h0000);
    expect_val("inc_gvalid_end", S_GVALID, 16'h0000);
    check();

    // Tiles 1 and 2 pressed together and held: one click, lowest index.
    // A write mid-hold advances to slot 2; a repeated click would pull it back.
    onclick = 4'b0110;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        recog_valid = 1'b1;
        recog_digit = 4'd9;
      end
      step();
      recog_valid = 1'b0;
      expect_val($sformatf("hold_active_c%0d", c), S_ACTIVE, (c < 5) ? 16'h0002 : 16'h0004);
      check();
    end
    onclick = 4'b0000;
    step();
    expect_val("hold_digits", S_DIGITS, 16'hF795);
    check();

    // Full row, submit, ready held low for five cycles then high.
    pulse_clear();
    recog(4'd9); recog(4'd8); recog(4'd7); recog(4'd6);
    expect_val("row_digits", S_DIGITS, 16'h6789);
    check();
    pulse_submit();
    for (int c = 1; c <= 5; c++) begin
      expect_val($sformatf("send_gvalid_c%0d", c), S_GVALID, 16'h0001);
      expect_val($sformatf("send_guess_c%0d", c),  S_GUESS,  16'h6789);
      check();
      if (c < 5) begin
        // Edits during SEND must be ignored.
        recog_valid = (c == 2);
        recog_digit = 4'd5;
        clear       = (c == 3);
        step();
        recog_valid = 1'b0;
        clear       = 1'b0;
      end
    end
    guess_ready = 1'b1;
    expect_val("xfer_gvalid", S_GVALID, 16'h0001);
    expect_val("xfer_guess",  S_GUESS,  16'h6789);
    check();
    step();
    guess_ready = 1'b0;
    expect_val("post_xfer_gvalid", S_GVALID, 16'h0000);
    expect_val("post_xfer_digits", S_DIGITS, 16'hFFFF);
    expect_val("post_xfer_active", S_ACTIVE, 16'h0001);
    expect_val("blink_k0",         S_BORDER, 16'h0000);
    check();

    // Blink: the transfer moved active to slot 0, restarting the counter.
    for (int k = 1; k <= 12; k++) begin
      step();
      expect_val($sformatf("blink_k%0d", k), S_BORDER, (((k / 4) % 2) == 1) ? 16'h0001 : 16'h0000);
      check();
    end

    // Selecting tile 3 while the border is off restarts the blink.
    onclick = 4'b1000;
    step();
    onclick = 4'b0000;
    expect_val("reblink_active", S_ACTIVE, 16'h0008);
    expect_val("reblink_j0",     S_BORDER, 16'h0000);
    check();
    for (int j = 1; j <= 4; j++) begin
      step();
      expect_val($sformatf("reblink_j%0d", j), S_BORDER, (j == 4) ? 16'h0008 : 16'h0000);
      check();
    end

    // Reset while a guess is being offered drops it.
    onclick = 4'b0001;
    step();
    onclick = 4'b0000;
    recog(4'd1); recog(4'd2); recog(4'd3); recog(4'd4);
    pulse_submit();
    expect_val("pre_rst_gvalid", S_GVALID, 16'h0001);
    check();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_reset_state("mid_send_rst");
    check();
    step();
    expect_val("after_rst_gvalid", S_GVALID, 16'h0000);
    expect_val("after_rst_digits", S_DIGITS, 16'hFFFF);
    check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
